jt5205_interpol: RTL and testbench
==================================

# jt5205_interpol

Parametrised N-times upsampling interpolator for the JT5205 ADPCM output path. It is the next-generation replacement for the fixed 2x averager. It takes signed samples at the decoder rate (`cen_in`) and produces 2^LOG2R output samples per input period (`cen_out`). In linear mode it ramps from the previous sample to the newest one; in hold mode it repeats the newest sample. It sits between the ADPCM decoder and the mixer/filter stage.

## Interface
- `DW`, default 12: sample width, signed two's complement.
- `LOG2R`, default 1: log2 of the interpolation ratio, so R = 2^LOG2R. Legal range is 1..4.
- `clk` in 1: system clock. All state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `cen_in` in 1: one-cycle strobe; `din` is valid on this cycle.
- `cen_out` in 1: one-cycle strobe at R× the `cen_in` rate; one output step per strobe.
- `lin` in 1: mode select. 1 = linear interpolation, 0 = zero-order hold. Sampled on every `cen_out`.
- `din` in DW: signed input sample.
- `dout` out DW: signed interpolated sample, registered.

## Operation
- Internal state:
  - `cur` (DW): newest input.
  - `delta` (DW+1, signed).
  - `acc` (DW+LOG2R+1, signed): current value scaled by R.
  - `step` (LOG2R+1 bits, unsigned): range 0..R.
- Reload, on `cen_in`:
  - `delta <= din - cur`
  - `acc <= cur <<< LOG2R` (uses the old `cur`)
  - `cur <= din`
  - `step <= 0`
  - `cen_in` alone does not change `dout`.
- Step, on `cen_out` with `lin=1`:
  - If `step < R`: `acc <= acc + delta`, `step <= step + 1`, `dout <= (acc + delta) >>> LOG2R`.
  - If `step == R` (saturated, input late): `acc`, `step` and `dout` hold.
- On `cen_out` with `lin=0`: `dout <= cur`. `acc` and `step` still advance exactly as in linear mode, so switching modes mid-period stays consistent.
- Coincident `cen_in` and `cen_out` in the same cycle:
  - Reload and first step both apply, computed from the reload values.
  - `acc <= (cur <<< LOG2R) + (din - cur)`, `step <= 1`.
  - `dout` = that sum `>>> LOG2R` when `lin=1`; `dout` = `din` when `lin=0`.
- Arithmetic:
  - The right shift is arithmetic, i.e. floor rounding. No round-half-up.
  - After R steps, `acc` equals `cur <<< LOG2R` exactly, so the ramp lands on the input sample with no drift.
  - Intermediate values always lie between two DW-bit samples, so `dout` never overflows and no saturation logic is needed.
- `cen_in` arriving before R steps complete: reload restarts the ramp from the old `cur`, not from the partially ramped `dout`. A step discontinuity in that case is accepted.
- Reset: `cur`, `delta`, `acc` and `dout` clear to 0; `step` is set to R (saturated). Any `cen_out` before the first `cen_in` therefore outputs 0. Reset mid-ramp discards the ramp immediately, and the next cycle behaves as post-reset.

## Timing
- Reset value of `dout` is 0, visible the cycle after `rst` is sampled high.
- `dout` updates on the clock edge where `cen_out` is high, and only there.
- Linear mode has one input-period group delay: the ramp toward sample n runs during the period after `cen_in` for n. Output k (k = 1..R) equals floor(prev + k·(n−prev)/R), where prev is the old `cur`.
- Hold mode latency: `dout` shows `din` at the first `cen_out` on or after its `cen_in`.
- No handshake or backpressure. Strobes are free-running and assumed to be at most one clock wide.
- Throughput: one `cen_out` per clock is supported (back-to-back strobes allowed).

## Test plan
- DW=12, LOG2R=2, `lin=1`: `cen_in` 0 then `cen_in` 400, followed by 4 `cen_out` → `dout` = 100, 200, 300, 400. A 5th `cen_out` before the next `cen_in` → `dout` stays 400.
- Continuing: `cen_in` −400, then 4 `cen_out` → 200, 0, −200, −400. Then `cen_in` 3 after `cen_in` 0, then 4 `cen_out` → 0, 1, 2, 3 (floor rounding).
- Full-scale swing: `cur`=2047, `cen_in` −2048, then 4 `cen_out` → 1023, −1, −1025, −2048, with no wrap.
- Coincident strobes: `cur`=0, `cen_in`=400 and `cen_out` in the same cycle → `dout`=100 and `step`=1. The next 3 `cen_out` → 200, 300, 400.
- Hold mode (`lin=0`): `cen_in` 400, `cen_out` ×4 → 400 each time. Switch to `lin=1` mid-period (after 2 steps), then 2 more `cen_out` → 300, 400.
- Reset mid-ramp: `rst` high after 2 of 4 steps → `dout`=0 next cycle. Further `cen_out` before any `cen_in` → 0. Repeat the first scenario with LOG2R=1 → 200, 400.

Source files
------------

// File: rtl/jt5205_interpol.sv
// 2^LOG2R-times upsampler for ADPCM samples: linear ramp from the previous sample or zero-order hold.
// dout is registered and changes only on the cen_out edge. There is no backpressure; strobes are free-running.
module jt5205_interpol #(
  parameter int DW    = 12,
  parameter int LOG2R = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen_in,
  input  logic          cen_out,
  input  logic          lin,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  localparam int AW = DW + LOG2R + 1;
  localparam int SW = LOG2R + 1;
  localparam logic [SW-1:0] R = SW'(1 << LOG2R);

  logic signed [DW-1:0] cur;
  logic signed [DW:0]   delta;
  logic signed [AW-1:0] acc;
  logic [SW-1:0]        step;

  logic signed [DW:0]   new_delta;
  logic signed [AW-1:0] cur_sc;
  logic signed [AW-1:0] base;
  logic signed [AW-1:0] inc;
  logic signed [AW-1:0] acc_nxt;
  logic                 stepping;

  assign new_delta = $signed({din[DW-1], din}) - $signed({cur[DW-1], cur});
  assign cur_sc    = $signed({cur[DW-1], cur, {LOG2R{1'b0}}});

  // A coincident reload feeds the first step directly, so the step path
  // always works from the values the reload would have produced.
  assign base     = cen_in ? cur_sc : acc;
  assign inc      = cen_in ? $signed({{LOG2R{new_delta[DW]}}, new_delta})
                           : $signed({{LOG2R{delta[DW]}}, delta});
  assign acc_nxt  = base + inc;
  assign stepping = cen_in || (step < R);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur   <= '0;
      delta <= '0;
      acc   <= '0;
      step  <= R;
      dout  <= '0;
    end else begin
      if (cen_in) begin
        cur   <= din;
        delta <= new_delta;
      end
      if (cen_out && stepping) begin
        acc  <= acc_nxt;
        step <= cen_in ? SW'(1) : step + SW'(1);
      end else if (cen_in) begin
        acc  <= cur_sc;
        step <= '0;
      end
      // Hold mode ignores step saturation; linear mode freezes once the ramp is done.
      if (cen_out) begin
        if (!lin)
          dout <= cen_in ? din : cur;
        else if (stepping)
          dout <= acc_nxt[LOG2R +: DW];
      end
    end
  end

endmodule

// File: tb/tb_jt5205_interpol.sv
// Bench for jt5205_interpol: directed vectors on a 4x instance, then random strobes on 4x and 2x
// instances checked against a closed-form ramp model.
module tb_jt5205_interpol;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cen_in, cen_out, lin;
  logic [11:0] din;
  logic [11:0] dout4, dout2;

  jt5205_interpol #(.DW(12), .LOG2R(2)) u4 (
    .clk(clk), .rst(rst), .cen_in(cen_in), .cen_out(cen_out),
    .lin(lin), .din(din), .dout(dout4)
  );

  jt5205_interpol #(.DW(12), .LOG2R(1)) u2 (
    .clk(clk), .rst(rst), .cen_in(cen_in), .cen_out(cen_out),
    .lin(lin), .din(din), .dout(dout2)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: output k of a period is floor(prev + k*(cur-prev)/R).
  int rr[2] = '{4, 2};
  int m_prev[2], m_cur[2], m_k[2], m_dout[2];

  typedef struct {
    logic r, ci, co, l;
    int   d;
    int   exp;
    int   step_exp;
  } vec_t;
  vec_t vecs[$];

  function automatic int fdiv(int a, int r);
    int q = a / r;
    if ((a % r != 0) && (a < 0)) q--;
    return q;
  endfunction

  function automatic int sx12(logic [11:0] v);
    return int'($signed(v));
  endfunction

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_prev[i] = 0; m_cur[i] = 0; m_k[i] = rr[i]; m_dout[i] = 0;
      end else begin
        if (cen_in) begin
          m_prev[i] = m_cur[i];
          m_cur[i]  = sx12(din);
          m_k[i]    = 0;
        end
        if (cen_out) begin
          if (m_k[i] < rr[i]) begin
            m_k[i]++;
            if (lin)
              m_dout[i] = fdiv(m_prev[i] * rr[i] + m_k[i] * (m_cur[i] - m_prev[i]), rr[i]);
          end
          if (!lin) m_dout[i] = m_cur[i];
        end
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic ci, input logic co, input logic l, input int d);
    @(negedge clk);
    rst = r; cen_in = ci; cen_out = co; lin = l; din = 12'(d);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic add(input logic r, input logic ci, input logic co, input logic l,
                     input int d, input int e, input int s);
    vec_t v;
    v.r = r; v.ci = ci; v.co = co; v.l = l; v.d = d; v.exp = e; v.step_exp = s;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; cen_in = 1'b0; cen_out = 1'b0; lin = 1'b1; din = '0;

    // reset, ramp 0->400, saturation
    add(1,0,0,1,0,      0, 4);
    add(0,1,0,1,0,      0,-1);
    add(0,1,0,1,400,    0, 0);
    add(0,0,1,1,0,    100,-1);
    add(0,0,1,1,0,    200,-1);
    add(0,0,1,1,0,    300,-1);
    add(0,0,1,1,0,    400, 4);
    add(0,0,1,1,0,    400, 4);
    // downward ramp
    add(0,1,0,1,-400, 400,-1);
    add(0,0,1,1,0,    200,-1);
    add(0,0,1,1,0,      0,-1);
    add(0,0,1,1,0,   -200,-1);
    add(0,0,1,1,0,   -400,-1);
    // floor rounding
    add(0,1,0,1,0,   -400,-1);
    add(0,1,0,1,3,   -400,-1);
    add(0,0,1,1,0,      0,-1);
    add(0,0,1,1,0,      1,-1);
    add(0,0,1,1,0,      2,-1);
    add(0,0,1,1,0,      3,-1);
    // full-scale swing
    add(0,1,0,1,2047,   3,-1);
    add(0,1,0,1,-2048,  3,-1);
    add(0,0,1,1,0,   1023,-1);
    add(0,0,1,1,0,     -1,-1);
    add(0,0,1,1,0,  -1025,-1);
    add(0,0,1,1,0,  -2048,-1);
    // coincident strobes
    add(0,1,0,1,0,  -2048,-1);
    add(0,1,1,1,400,  100, 1);
    add(0,0,1,1,0,    200,-1);
    add(0,0,1,1,0,    300,-1);
    add(0,0,1,1,0,    400,-1);
    // hold mode
    add(0,1,0,0,-100, 400,-1);
    add(0,0,1,0,0,   -100,-1);
    add(0,1,0,0,400, -100,-1);
    add(0,0,1,0,0,    400,-1);
    add(0,0,1,0,0,    400,-1);
    add(0,0,1,0,0,    400,-1);
    add(0,0,1,0,0,    400, 4);
    // switch hold -> linear mid-period
    add(0,1,0,0,0,    400,-1);
    add(0,1,0,0,400,  400, 0);
    add(0,0,1,0,0,    400,-1);
    add(0,0,1,0,0,    400, 2);
    add(0,0,1,1,0,    300,-1);
    add(0,0,1,1,0,    400,-1);
    // reset mid-ramp
    add(0,1,0,1,0,    400,-1);
    add(0,1,0,1,400,  400,-1);
    add(0,0,1,1,0,    100,-1);
    add(0,0,1,1,0,    200,-1);
    add(1,0,0,1,0,      0, 4);
    add(0,0,1,1,0,      0,-1);
    add(0,0,1,1,0,      0,-1);

    foreach (vecs[i]) begin
      cyc(vecs[i].r, vecs[i].ci, vecs[i].co, vecs[i].l, vecs[i].d);
      check($sformatf("vec%0d_dout", i), sx12(dout4), vecs[i].exp);
      if (vecs[i].step_exp >= 0)
        check($sformatf("vec%0d_step", i), int'(u4.step), vecs[i].step_exp);
    end
    check("post_reset_dout2", sx12(dout2), 0);

    // 2x instance: ramp 0->400 in two steps, then saturate
    cyc(0,1,0,1,0);
    cyc(0,1,0,1,400);
    cyc(0,0,1,1,0);   check("r2_step1", sx12(dout2), 200);
    cyc(0,0,1,1,0);   check("r2_step2", sx12(dout2), 400);
    cyc(0,0,1,1,0);   check("r2_sat",   sx12(dout2), 400);

    // coincident strobes in hold mode pass din straight through
    cyc(0,1,1,0,123); check("hold_coinc4", sx12(dout4), 123);
    check("hold_coinc2", sx12(dout2), 123);

    // randomized run against the model on both ratios
    cyc(1,0,0,1,0);
    begin
      logic prev_ci = 1'b0;
      logic l = 1'b1;
      for (int n = 0; n < 4000; n++) begin
        logic ci, co, r;
        ci = ($urandom_range(0, 5) == 0) && !prev_ci;
        co = 1'($urandom_range(0, 1));
        r  = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 15) == 0) l = ~l;
        cyc(r, ci, co, l, int'($urandom_range(0, 4095)));
        prev_ci = ci;
        check($sformatf("rand4_%0d", n), sx12(dout4), m_dout[0]);
        check($sformatf("rand2_%0d", n), sx12(dout2), m_dout[1]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
